// File: rtl/brick_drop_sequencer.sv
// brick_drop_sequencer: three-column falling-brick game sequencer.
// Spawns and drops bricks, lands them, clears lines, keeps score.
module brick_drop_sequencer #(
  parameter int DROP_DIV = 25000000,
  parameter int TOP_ROW  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] col,
  output logic [2:0] row,
  output logic [2:0] hauteurGauche,
  output logic [2:0] hauteurCentre,
  output logic [2:0] hauteurDroite,
  output logic       landed,
  output logic [7:0] score,
  output logic       playing,
  output logic       game_over
);

  localparam int CW = $clog2(DROP_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DROP_DIV - 1);
  localparam logic [2:0] TOP = 3'(TOP_ROW);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FALL,
    LAND,
    CLEAR,
    OVER
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [1:0] col_m;
  logic [1:0] col_l;
  logic [2:0] h_l, h_c, h_r;
  logic [2:0] h_cur, h_land, h_land_inc;
  logic tick, hit, full;

  // column 3 is an alias of the centre column
  assign col_m = (col == 2'd3) ? 2'd1 : col;

  assign tick = (cnt == DIV_LAST);
  assign hit  = tick && (row <= h_cur);
  assign full = (h_l != 3'd0) && (h_c != 3'd0)
             && (h_r != 3'd0);

  assign hauteurGauche = h_l;
  assign hauteurCentre = h_c;
  assign hauteurDroite = h_r;

  // height under the falling brick and under the landed column
  always_comb begin
    h_cur = h_c;
    h_land = h_c;
    unique case (col_m)
      2'd0:    h_cur = h_l;
      2'd2:    h_cur = h_r;
      default: h_cur = h_c;
    endcase
    unique case (col_l)
      2'd0:    h_land = h_l;
      2'd2:    h_land = h_r;
      default: h_land = h_c;
    endcase
    h_land_inc = (h_land == 3'd7) ? 3'd7
                                  : h_land + 3'd1;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_n   = state;
    landed    = 1'b0;
    playing   = 1'b0;
    game_over = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SPAWN;
      end
      SPAWN: begin
        playing = 1'b1;
        state_n = FALL;
      end
      FALL: begin
        playing = 1'b1;
        if (hit) state_n = LAND;
      end
      LAND: begin
        playing = 1'b1;
        landed  = 1'b1;
        state_n = CLEAR;
      end
      CLEAR: begin
        playing = 1'b1;
        if (full)               state_n = SPAWN;
        else if (h_land >= TOP) state_n = OVER;
        else                    state_n = SPAWN;
      end
      OVER: begin
        game_over = 1'b1;
        if (start) state_n = SPAWN;
      end
      default: state_n = IDLE;
    endcase
  end

  // row, drop counter, heights and score
  always_ff @(posedge clk) begin
    if (reset) begin
      row   <= TOP;
      cnt   <= '0;
      col_l <= 2'd0;
      h_l   <= 3'd0;
      h_c   <= 3'd0;
      h_r   <= 3'd0;
      score <= 8'd0;
    end else begin
      unique case (state)
        SPAWN: begin
          row <= TOP;
          cnt <= '0;
        end
        FALL: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (row <= h_cur) col_l <= col_m;
            else              row   <= row - 3'd1;
          end
        end
        LAND: begin
          unique case (col_l)
            2'd0:    h_l <= h_land_inc;
            2'd2:    h_r <= h_land_inc;
            default: h_c <= h_land_inc;
          endcase
        end
        CLEAR: begin
          if (full) begin
            h_l <= h_l - 3'd1;
            h_c <= h_c - 3'd1;
            h_r <= h_r - 3'd1;
            if (score != 8'hFF) score <= score + 8'd1;
          end
        end
        OVER: begin
          if (start) begin
            h_l   <= 3'd0;
            h_c   <= 3'd0;
            h_r   <= 3'd0;
            score <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_drop_sequencer.sv
// tb_brick_drop_sequencer: directed brick table plus
// random games checked against a per-brick game model.
module tb_brick_drop_sequencer;

  localparam int DIV = 4;
  localparam int TOP = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] col;
  logic [2:0] row;
  logic [2:0] hl, hc, hr;
  logic       landed;
  logic [7:0] score;
  logic       playing;
  logic       game_over;

  int n_chk = 0;
  int n_fail = 0;
  bit rand_start = 1'b0;

  int mh [3];
  int ms;

  typedef struct {
    logic [1:0] c;
    int lat;
    int rw;
    int land_h;
    int l;
    int cc;
    int r;
    int s;
    bit over;
  } brick_t;

  brick_t tbl [16];

  brick_drop_sequencer #(
    .DROP_DIV(DIV),
    .TOP_ROW (TOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .col          (col),
    .row          (row),
    .hauteurGauche(hl),
    .hauteurCentre(hc),
    .hauteurDroite(hr),
    .landed       (landed),
    .score        (score),
    .playing      (playing),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d",
               nm, act, exp);
    end
  endtask

  function automatic brick_t mk(
    input int c, input int lat, input int rw,
    input int lh, input int l, input int cc,
    input int r, input int s, input bit ov);
    brick_t b;
    b.c = 2'(c);
    b.lat = lat;
    b.rw = rw;
    b.land_h = lh;
    b.l = l;
    b.cc = cc;
    b.r = r;
    b.s = s;
    b.over = ov;
    return b;
  endfunction

  // Game-level model: a brick spawned at the top row
  // stops on the stack, i.e. at row h, after one drop
  // period per row travelled plus the final tick.
  task automatic predict(input logic [1:0] c,
                         output brick_t b);
    int cm;
    int h;
    cm = (c == 2'd3) ? 1 : int'(c);
    h = mh[cm];
    b.c = c;
    b.rw = h;
    b.lat = DIV * (TOP - h + 1);
    mh[cm] = (h >= 7) ? 7 : h + 1;
    b.land_h = mh[cm];
    b.over = 1'b0;
    if (mh[0] >= 1 && mh[1] >= 1 && mh[2] >= 1) begin
      for (int k = 0; k < 3; k++) mh[k]--;
      ms = (ms >= 255) ? 255 : ms + 1;
    end else if (mh[cm] >= TOP) begin
      b.over = 1'b1;
    end
    b.l = mh[0];
    b.cc = mh[1];
    b.r = mh[2];
    b.s = ms;
  endtask

  // Starts at a SPAWN cycle; ends one cycle after CLEAR.
  task automatic run_brick(input brick_t b,
                           input int idx);
    int lat;
    int cm;
    logic [2:0] hland;
    lat = -1;
    check($sformatf("b%0d_spawn_playing", idx),
          playing, 1);
    col = b.c;
    step(1);
    check($sformatf("b%0d_fall_row", idx), row, TOP);
    for (int i = 1; i <= 40; i++) begin
      if (rand_start) start = 1'($urandom_range(0, 1));
      step(1);
      if (landed) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check($sformatf("b%0d_latency", idx), lat, b.lat);
    if (lat < 0) return;
    check($sformatf("b%0d_land_row", idx), row, b.rw);
    step(1);
    check($sformatf("b%0d_landed_pulse", idx),
          landed, 0);
    cm = (b.c == 2'd3) ? 1 : int'(b.c);
    hland = (cm == 0) ? hl : (cm == 2) ? hr : hc;
    check($sformatf("b%0d_post_land_h", idx),
          hland, b.land_h);
    step(1);
    check($sformatf("b%0d_h_left", idx), hl, b.l);
    check($sformatf("b%0d_h_centre", idx), hc, b.cc);
    check($sformatf("b%0d_h_right", idx), hr, b.r);
    check($sformatf("b%0d_score", idx), score, b.s);
    check($sformatf("b%0d_game_over", idx),
          game_over, b.over);
    check($sformatf("b%0d_playing", idx),
          playing, !b.over);
  endtask

  initial begin
    bit frozen;
    brick_t b;
    logic [1:0] c;

    tbl[0]  = mk(0, 32, 0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32, 0, 1, 1, 1, 0, 0, 0);
    tbl[2]  = mk(2, 32, 0, 1, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 32, 0, 1, 0, 1, 0, 1, 0);
    tbl[4]  = mk(1, 28, 1, 2, 0, 2, 0, 1, 0);
    tbl[5]  = mk(1, 24, 2, 3, 0, 3, 0, 1, 0);
    tbl[6]  = mk(1, 20, 3, 4, 0, 4, 0, 1, 0);
    tbl[7]  = mk(1, 16, 4, 5, 0, 5, 0, 1, 0);
    tbl[8]  = mk(1, 12, 5, 6, 0, 6, 0, 1, 0);
    tbl[9]  = mk(1,  8, 6, 7, 0, 7, 0, 1, 1);
    tbl[10] = mk(2, 32, 0, 1, 0, 0, 1, 0, 0);
    tbl[11] = mk(2, 28, 1, 2, 0, 0, 2, 0, 0);
    tbl[12] = mk(2, 24, 2, 3, 0, 0, 3, 0, 0);
    tbl[13] = mk(2, 20, 3, 4, 0, 0, 4, 0, 0);
    tbl[14] = mk(2, 16, 4, 5, 0, 0, 5, 0, 0);
    tbl[15] = mk(3, 32, 0, 1, 0, 1, 5, 0, 0);

    reset = 1'b1;
    start = 1'b0;
    col = 2'd0;
    step(2);
    reset = 1'b0;
    check("rst_row", row, TOP);
    check("rst_h_left", hl, 0);
    check("rst_h_centre", hc, 0);
    check("rst_h_right", hr, 0);
    check("rst_score", score, 0);
    check("rst_landed", landed, 0);
    check("rst_game_over", game_over, 0);
    check("rst_playing", playing, 0);
    step(3);
    check("idle_hold_playing", playing, 0);

    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start_spawn_playing", playing, 1);

    for (int i = 0; i < 16; i++) begin
      run_brick(tbl[i], i);
      if (tbl[i].over) begin
        frozen = 1'b1;
        for (int k = 0; k < 100; k++) begin
          step(1);
          if (row !== 3'd6 || hl !== 3'd0
              || hc !== 3'd7 || hr !== 3'd0
              || score !== 8'd1 || game_over !== 1'b1
              || playing !== 1'b0 || landed !== 1'b0)
            frozen = 1'b0;
        end
        check("over_frozen_100", frozen, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_h_left", hl, 0);
        check("restart_h_centre", hc, 0);
        check("restart_h_right", hr, 0);
        check("restart_score", score, 0);
        check("restart_game_over", game_over, 0);
      end
    end

    col = 2'd0;
    step(1);
    check("midfall_entry_row", row, TOP);
    step(13);
    check("midfall_row4", row, 4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_row", row, TOP);
    check("midrst_h_centre", hc, 0);
    check("midrst_h_right", hr, 0);
    check("midrst_score", score, 0);
    check("midrst_landed", landed, 0);
    check("midrst_playing", playing, 0);
    step(10);
    check("midrst_idle_playing", playing, 0);
    check("midrst_idle_row", row, TOP);

    mh = '{0, 0, 0};
    ms = 0;
    rand_start = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 0)
        c = 2'($urandom_range(0, 3));
      else
        c = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3;
      predict(c, b);
      run_brick(b, 100 + k);
      if (b.over) begin
        step($urandom_range(1, 5));
        check($sformatf("r%0d_over_wait", k),
              game_over, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        mh = '{0, 0, 0};
        ms = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/brick_drop_sequencer.md
Name: brick_drop_sequencer

Overview:
Game sequencer for the three-column falling-brick game.
- Spawns each brick at the top row and steps it down one row per drop period.
- Lands the brick on the column selected by the player controller and updates the three column heights.
- Clears a full bottom line, counts score and detects game over.
- Its row/height outputs feed the player controller's move checks; that controller's column output feeds back as `col`.

Parameters:
- DROP_DIV, 25000000, clk cycles per one-row drop step (must be >= 2).
- TOP_ROW, 7, spawn row and game-over height (must be <= 7, 3-bit range).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; starts a game from IDLE or OVER.
- col  input  2  current brick column from the player controller (0 left, 1 centre, 2 right; 3 treated as 1).
- row  output  3  current brick row (0 = bottom).
- hauteurGauche  output  3  left column stack height.
- hauteurCentre  output  3  centre column stack height.
- hauteurDroite  output  3  right column stack height.
- landed  output  1  one-cycle pulse while in LAND.
- score  output  8  cleared-line count, saturates at 255.
- playing  output  1  high in SPAWN, FALL, LAND and CLEAR.
- game_over  output  1  high in OVER.

Behaviour:
- Reset (synchronous, wins over everything, any state, mid-fall included):
  - state = IDLE, row = TOP_ROW, all heights = 0, score = 0.
  - landed = 0, game_over = 0, drop counter = 0.
- IDLE: start=1 → SPAWN next cycle. start=0 → stay.
- SPAWN (1 cycle): row <= TOP_ROW, counter <= 0 → FALL.
- FALL:
  - Counter increments every cycle. The cycle where counter == DROP_DIV-1 is a "tick"; the counter returns to 0 on a tick.
  - On a tick, with h = height[col] sampled that cycle:
    - If row <= h: latch col into colL, → LAND.
    - Else: row <= row-1.
  - No action between ticks.
  - start is ignored in FALL, LAND and CLEAR.
- LAND (1 cycle):
  - landed = 1.
  - height[colL] <= height[colL]+1, saturating at 7.
  - row holds its value. → CLEAR.
- CLEAR (1 cycle), evaluated on the post-LAND heights:
  - If all three heights >= 1: every height decrements by 1, score increments (saturating), → SPAWN.
  - Else if height[colL] >= TOP_ROW: → OVER.
  - Else: → SPAWN.
- OVER:
  - game_over = 1; heights, score and row are frozen.
  - start=1 → heights <= 0, score <= 0, → SPAWN.
- Height outputs are registered. Updates are visible the cycle after LAND or CLEAR.
- Only one column changes per landing, so at most one line clear per landing.
- The col change rules are owned by the player controller. If col points to a column with h > row (illegal), the brick lands on the next tick and height increments as normal.

Test Plan (DROP_DIV=4, TOP_ROW=7):
1. Reset, start pulse with col=0 → SPAWN 1 cycle later, FALL 2 cycles later. Row steps 7→6→…→0, one step every 4 cycles. landed pulses once, 32 cycles after FALL entry. hauteurGauche=1 on the next cycle; score=0.
2. Heights {L,C,R}={0,2,0}, brick on col=1 → land tick occurs at row=2. hauteurCentre=3 and landed high for exactly 1 cycle.
3. Heights {1,1,0}, brick lands col=2 → after LAND, R=1. After CLEAR, heights {0,0,0} and score=1; next state SPAWN.
4. Heights {0,6,0}, brick lands col=1 → C=7, game_over=1 and playing=0. Row and heights frozen for 100 cycles. Then start=1 → heights 0, score 0, new brick at row 7.
5. Assert reset mid-FALL at row=4 → next cycle: state IDLE, row=7, heights 0, score 0, landed 0. start held low → stays IDLE.
6. col=3 during FALL with heights {0,0,5} → landing height taken from centre; brick lands at row=0 and hauteurCentre becomes 1.
